// File: rtl/hygro_sensor_sequencer_if.sv
// Command/handshake bundle between the HDC1080 sequencer (master side)
// and the I2C master engine it drives (slave side).
interface hygro_sensor_sequencer_if;
    logic       start;
    logic       ready;
    logic       i2cBusy;
    logic       data_request;
    logic       data_available;
    logic       data_valid;
    logic       read_nwrite;
    logic [6:0] addr;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic [2:0] data_size;

    modport master (
        output start, data_valid, read_nwrite, addr, data_i, data_size,
        input  ready, i2cBusy, data_request, data_available, data_o
    );

    modport slave (
        input  start, data_valid, read_nwrite, addr, data_i, data_size,
        output ready, i2cBusy, data_request, data_available, data_o
    );
endinterface

// File: rtl/hygro_sensor_sequencer.sv
// Autonomous HDC1080 client: configures the sensor after reset, then runs
// trigger / conversion wait / 4-byte read cycles on each measurement request.
module hygro_sensor_sequencer #(
    parameter logic [6:0]  DEV_ADDR       = 7'h40,
    parameter int unsigned CONV_CYCLES    = 2000000,
    parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
    input  logic                            clk,
    input  logic                            rst,
    hygro_sensor_sequencer_if.master        i2c,
    input  logic                            measure_i,
    input  logic                            cfg_update_i,
    input  logic                            heater_i,
    input  logic                            tres_i,
    input  logic [1:0]                      hres_i,
    output logic [15:0]                     temperature_o,
    output logic [15:0]                     humidity_o,
    output logic                            result_valid_o,
    output logic                            busy_o,
    output logic                            error_o
);

    localparam int CONV_W    = $clog2(CONV_CYCLES + 32'd1);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 32'd1);

    localparam logic [CONV_W-1:0]    CONV_LAST    = CONV_W'(CONV_CYCLES - 32'd1);
    localparam logic [CONV_W-1:0]    CONV_ZERO    = CONV_W'(1'b0);
    localparam logic [CONV_W-1:0]    CONV_ONE     = CONV_W'(1'b1);
    localparam logic [TIMEOUT_W-1:0] TIMER_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [TIMEOUT_W-1:0] TIMER_ZERO   = TIMEOUT_W'(1'b0);
    localparam logic [TIMEOUT_W-1:0] TIMER_ONE    = TIMEOUT_W'(1'b1);

    typedef enum logic [3:0] {
        CFG_START  = 4'd0,
        CFG_WAIT   = 4'd1,
        IDLE       = 4'd2,
        TRIG_START = 4'd3,
        TRIG_WAIT  = 4'd4,
        CONV       = 4'd5,
        RD_START   = 4'd6,
        RD_WAIT    = 4'd7,
        DONE       = 4'd8
    } state_e;

    state_e                 state_q;
    logic                   start_q;
    logic                   req_q;
    logic                   avail_q;
    logic [2:0]             byte_idx_q;
    logic [TIMEOUT_W-1:0]   timer_q;
    logic [CONV_W-1:0]      conv_cnt_q;
    logic [7:0]             cfg_byte_q;
    logic [31:0]            shadow_q;
    logic [15:0]            temperature_q;
    logic [15:0]            humidity_q;
    logic                   result_valid_q;
    logic                   error_q;
    logic                   meas_pend_q;
    logic                   cfg_pend_q;

    logic                   is_start_s;
    logic                   is_wait_s;
    logic                   is_write_s;
    logic                   is_read_s;
    logic [2:0]             data_size_s;
    logic                   read_nwrite_s;
    logic [7:0]             data_byte_s;
    state_e                 wait_next_s;
    state_e                 done_next_s;
    logic                   byte_edge_s;
    logic                   timeout_s;

    // State decode: transaction shape, write byte mux and successor states
    always_comb begin
        is_start_s    = 1'b0;
        is_wait_s     = 1'b0;
        is_write_s    = 1'b0;
        is_read_s     = 1'b0;
        data_size_s   = 3'd0;
        read_nwrite_s = 1'b0;
        data_byte_s   = 8'h00;
        wait_next_s   = IDLE;
        done_next_s   = IDLE;
        case (state_q)
            CFG_START, CFG_WAIT: begin
                is_start_s  = (state_q == CFG_START);
                is_wait_s   = (state_q == CFG_WAIT);
                is_write_s  = 1'b1;
                data_size_s = 3'd3;
                wait_next_s = CFG_WAIT;
                done_next_s = IDLE;
                case (byte_idx_q)
                    3'd0:    data_byte_s = 8'h02;
                    3'd1:    data_byte_s = cfg_byte_q;
                    default: data_byte_s = 8'h00;
                endcase
            end
            TRIG_START, TRIG_WAIT: begin
                is_start_s  = (state_q == TRIG_START);
                is_wait_s   = (state_q == TRIG_WAIT);
                is_write_s  = 1'b1;
                data_size_s = 3'd1;
                wait_next_s = TRIG_WAIT;
                done_next_s = CONV;
            end
            RD_START, RD_WAIT: begin
                is_start_s    = (state_q == RD_START);
                is_wait_s     = (state_q == RD_WAIT);
                is_read_s     = 1'b1;
                data_size_s   = 3'd4;
                read_nwrite_s = 1'b1;
                wait_next_s   = RD_WAIT;
                done_next_s   = DONE;
            end
            default: begin
                data_size_s = 3'd0;
            end
        endcase
    end

    // A byte only counts while the transaction still has room for it
    assign byte_edge_s = ((is_write_s & i2c.data_request & ~req_q) |
                          (is_read_s & i2c.data_available & ~avail_q)) &
                         (byte_idx_q < data_size_s);
    assign timeout_s   = (is_start_s | is_wait_s) & (timer_q == TIMER_LAST);

    // Sequencer state, handshake, pending requests and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= CFG_START;
            start_q        <= 1'b0;
            req_q          <= 1'b0;
            avail_q        <= 1'b0;
            byte_idx_q     <= 3'd0;
            timer_q        <= TIMER_ZERO;
            conv_cnt_q     <= CONV_ZERO;
            cfg_byte_q     <= 8'h10;
            shadow_q       <= 32'h0000_0000;
            temperature_q  <= 16'h0000;
            humidity_q     <= 16'h0000;
            result_valid_q <= 1'b0;
            error_q        <= 1'b0;
            meas_pend_q    <= 1'b0;
            cfg_pend_q     <= 1'b0;
        end else begin
            req_q          <= i2c.data_request;
            avail_q        <= i2c.data_available;
            result_valid_q <= 1'b0;
            if (measure_i) begin
                meas_pend_q <= 1'b1;
            end
            if (cfg_update_i) begin
                cfg_pend_q <= 1'b1;
            end
            if (byte_edge_s) begin
                byte_idx_q <= byte_idx_q + 3'd1;
                if (is_read_s) begin
                    shadow_q <= {shadow_q[23:0], i2c.data_o};
                end
            end
            if (is_start_s || is_wait_s) begin
                timer_q <= timer_q + TIMER_ONE;
            end

            if (timeout_s) begin
                start_q <= 1'b0;
                error_q <= 1'b1;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    CFG_START, TRIG_START, RD_START: begin
                        // Switches are tracked until the config transaction launches
                        if (state_q == CFG_START && !start_q) begin
                            cfg_byte_q <= {2'b00, heater_i, 1'b1, 1'b0, tres_i, hres_i};
                        end
                        if (!start_q) begin
                            if (i2c.ready && !i2c.i2cBusy) begin
                                start_q <= 1'b1;
                            end
                        end else if (!i2c.ready) begin
                            start_q <= 1'b0;
                            state_q <= wait_next_s;
                            timer_q <= TIMER_ZERO;
                        end
                    end
                    CFG_WAIT, TRIG_WAIT, RD_WAIT: begin
                        if (i2c.ready) begin
                            state_q    <= done_next_s;
                            conv_cnt_q <= CONV_ZERO;
                        end
                    end
                    IDLE: begin
                        if (cfg_pend_q) begin
                            state_q    <= CFG_START;
                            cfg_pend_q <= 1'b0;
                            byte_idx_q <= 3'd0;
                            timer_q    <= TIMER_ZERO;
                        end else if (meas_pend_q) begin
                            state_q     <= TRIG_START;
                            meas_pend_q <= 1'b0;
                            byte_idx_q  <= 3'd0;
                            timer_q     <= TIMER_ZERO;
                        end
                    end
                    CONV: begin
                        if (conv_cnt_q == CONV_LAST) begin
                            state_q    <= RD_START;
                            byte_idx_q <= 3'd0;
                            timer_q    <= TIMER_ZERO;
                        end else begin
                            conv_cnt_q <= conv_cnt_q + CONV_ONE;
                        end
                    end
                    DONE: begin
                        // A short read keeps the previous result and flags the fault
                        if (byte_idx_q == 3'd4) begin
                            temperature_q  <= shadow_q[31:16];
                            humidity_q     <= shadow_q[15:0];
                            result_valid_q <= 1'b1;
                            error_q        <= 1'b0;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q    <= CFG_START;
                        start_q    <= 1'b0;
                        byte_idx_q <= 3'd0;
                        timer_q    <= TIMER_ZERO;
                    end
                endcase
            end
        end
    end

    assign i2c.start       = start_q;
    assign i2c.addr        = DEV_ADDR;
    assign i2c.data_valid  = 1'b1;
    assign i2c.data_i      = data_byte_s;
    assign i2c.data_size   = data_size_s;
    assign i2c.read_nwrite = read_nwrite_s;

    assign temperature_o   = temperature_q;
    assign humidity_o      = humidity_q;
    assign result_valid_o  = result_valid_q;
    assign busy_o          = (state_q != IDLE);
    assign error_o         = error_q;

endmodule

// File: tb/tb_hygro_sensor_sequencer.sv
// Directed bench for hygro_sensor_sequencer: the bench plays the I2C master
// and checks configuration, measurement, priority, bus-busy, short-read and timeout behaviour.
module tb_hygro_sensor_sequencer;

    localparam int CONV = 100;
    localparam int TO   = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        measure = 1'b0;
    logic        cfg_update = 1'b0;
    logic        heater = 1'b0;
    logic        tres = 1'b0;
    logic [1:0]  hres = 2'b00;
    logic [15:0] temperature;
    logic [15:0] humidity;
    logic        result_valid;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    hygro_sensor_sequencer_if bus ();

    hygro_sensor_sequencer #(
        .DEV_ADDR       (7'h40),
        .CONV_CYCLES    (CONV),
        .TIMEOUT_CYCLES (TO)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i2c            (bus),
        .measure_i      (measure),
        .cfg_update_i   (cfg_update),
        .heater_i       (heater),
        .tres_i         (tres),
        .hres_i         (hres),
        .temperature_o  (temperature),
        .humidity_o     (humidity),
        .result_valid_o (result_valid),
        .busy_o         (busy),
        .error_o        (error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic pulse_measure();
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Acts as the I2C master for one transaction and reports what it saw
    task automatic master_txn(input int nbytes, input logic [31:0] rdata,
                              output logic ok, output logic [2:0] size,
                              output logic rnw, output logic [31:0] wbytes,
                              output logic dropped);
        logic [31:0] rd;
        rd = rdata;
        wbytes = 32'h0;
        dropped = 1'b0;
        wait_start(ok);
        size = bus.data_size;
        rnw  = bus.read_nwrite;
        if (ok) begin
            bus.ready = 1'b0;
            @(negedge clk);
            dropped = (bus.start === 1'b0);
            for (int k = 0; k < nbytes; k++) begin
                wbytes = {wbytes[23:0], bus.data_i};
                if (rnw === 1'b1) begin
                    bus.data_o = rd[31:24];
                    rd = {rd[23:0], 8'h00};
                    bus.data_available = 1'b1;
                end else begin
                    bus.data_request = 1'b1;
                end
                @(negedge clk);
                bus.data_request   = 1'b0;
                bus.data_available = 1'b0;
                @(negedge clk);
            end
            bus.ready = 1'b1;
        end
    endtask

    task automatic collect_result(output int pulses, output logic [15:0] t, output logic [15:0] h);
        pulses = 0;
        t = temperature;
        h = humidity;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                pulses++;
                t = temperature;
                h = humidity;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0b expected 0", bus.start); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %0b expected 1", busy); end
        n_checks++; if ({result_valid, error} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %0b expected 00", {result_valid, error}); end
        n_checks++; if ({temperature, humidity} !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %08h expected 00000000", {temperature, humidity}); end
        n_checks++; if (bus.addr !== 7'h40 || bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL const_outputs: got addr %02h dv %0b expected 40 1", bus.addr, bus.data_valid); end
        n_checks++; if (bus.data_size !== 3'd3 || bus.read_nwrite !== 1'b0) begin n_fail++; $display("FAIL reset_shape: got size %0d rnw %0b expected 3 0", bus.data_size, bus.read_nwrite); end
    endtask

    task automatic test_config();
        logic ok, rnw, dr; logic [2:0] sz; logic [31:0] wb;
        rst = 1'b0;
        master_txn(3, 32'h0, ok, sz, rnw, wb, dr);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL cfg_start_seen: got %0b expected 1", ok); end
        n_checks++; if (sz !== 3'd3 || rnw !== 1'b0) begin n_fail++; $display("FAIL cfg_shape: got size %0d rnw %0b expected 3 0", sz, rnw); end
        n_checks++; if (wb[23:0] !== 24'h021000) begin n_fail++; $display("FAIL cfg_bytes: got %06h expected 021000", wb[23:0]); end
        n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL cfg_start_drop: got %0b expected 1", dr); end
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || bus.start !== 1'b0) begin n_fail++; $display("FAIL cfg_idle: got busy %0b start %0b expected 0 0", busy, bus.start); end
    endtask

    task automatic test_measure();
        logic ok, rnw, dr; logic [2:0] sz; logic [31:0] wb; int cnt, pulses; logic [15:0] t, h;
        pulse_measure();
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        n_checks++; if (ok !== 1'b1 || sz !== 3'd1 || rnw !== 1'b0) begin n_fail++; $display("FAIL trig_shape: got ok %0b size %0d rnw %0b expected 1 1 0", ok, sz, rnw); end
        n_checks++; if (wb[7:0] !== 8'h00) begin n_fail++; $display("FAIL trig_byte: got %02h expected 00", wb[7:0]); end
        // one cycle to leave TRIG_WAIT, CONV cycles of conversion, one cycle to raise start
        cnt = 0;
        while (bus.start !== 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++; if (cnt !== CONV + 2) begin n_fail++; $display("FAIL conv_delay: got %0d expected %0d", cnt, CONV + 2); end
        master_txn(4, 32'h665A_8001, ok, sz, rnw, wb, dr);
        n_checks++; if (ok !== 1'b1 || sz !== 3'd4 || rnw !== 1'b1) begin n_fail++; $display("FAIL read_shape: got ok %0b size %0d rnw %0b expected 1 4 1", ok, sz, rnw); end
        collect_result(pulses, t, h);
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL result_pulse: got %0d expected 1", pulses); end
        n_checks++; if (t !== 16'h665A || h !== 16'h8001) begin n_fail++; $display("FAIL result_value: got %04h %04h expected 665a 8001", t, h); end
        n_checks++; if (error !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL measure_end: got err %0b busy %0b expected 0 0", error, busy); end
    endtask

    task automatic test_cfg_priority();
        logic ok, rnw, dr; logic [2:0] sz; logic [31:0] wb; int pulses; logic [15:0] t, h;
        pulse_measure();
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        repeat (10) @(negedge clk);
        heater = 1'b1;
        hres = 2'b10;
        measure = 1'b1;
        cfg_update = 1'b1;
        @(negedge clk);
        measure = 1'b0;
        cfg_update = 1'b0;
        master_txn(4, 32'h1234_5678, ok, sz, rnw, wb, dr);
        n_checks++; if (sz !== 3'd4 || rnw !== 1'b1) begin n_fail++; $display("FAIL prio_read_first: got size %0d rnw %0b expected 4 1", sz, rnw); end
        collect_result(pulses, t, h);
        n_checks++; if (pulses !== 1 || t !== 16'h1234 || h !== 16'h5678) begin n_fail++; $display("FAIL prio_result: got %0d %04h %04h expected 1 1234 5678", pulses, t, h); end
        master_txn(3, 32'h0, ok, sz, rnw, wb, dr);
        n_checks++; if (sz !== 3'd3 || rnw !== 1'b0) begin n_fail++; $display("FAIL prio_cfg_next: got size %0d rnw %0b expected 3 0", sz, rnw); end
        n_checks++; if (wb[23:0] !== 24'h023200) begin n_fail++; $display("FAIL prio_cfg_bytes: got %06h expected 023200", wb[23:0]); end
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        n_checks++; if (ok !== 1'b1 || sz !== 3'd1 || rnw !== 1'b0) begin n_fail++; $display("FAIL prio_trig_next: got ok %0b size %0d rnw %0b expected 1 1 0", ok, sz, rnw); end
        master_txn(4, 32'hA1B2_C3D4, ok, sz, rnw, wb, dr);
        collect_result(pulses, t, h);
        n_checks++; if (t !== 16'hA1B2 || h !== 16'hC3D4) begin n_fail++; $display("FAIL prio_second_result: got %04h %04h expected a1b2 c3d4", t, h); end
    endtask

    task automatic test_i2c_busy();
        logic ok, rnw, dr, seen; logic [2:0] sz; logic [31:0] wb; int pulses; logic [15:0] t, h;
        bus.i2cBusy = 1'b1;
        pulse_measure();
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.start !== 1'b0) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got start_seen %0b busy %0b expected 0 1", seen, busy); end
        bus.i2cBusy = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.start !== 1'b1) begin n_fail++; $display("FAIL busy_release: got %0b expected 1", bus.start); end
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        master_txn(4, 32'h0BAD_F00D, ok, sz, rnw, wb, dr);
        collect_result(pulses, t, h);
        n_checks++; if (pulses !== 1 || t !== 16'h0BAD || h !== 16'hF00D) begin n_fail++; $display("FAIL busy_result: got %0d %04h %04h expected 1 0bad f00d", pulses, t, h); end
    endtask

    task automatic test_short_read();
        logic ok, rnw, dr; logic [2:0] sz; logic [31:0] wb; int pulses; logic [15:0] t, h;
        pulse_measure();
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        master_txn(2, 32'hDEAD_BEEF, ok, sz, rnw, wb, dr);
        collect_result(pulses, t, h);
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL short_pulse: got %0d expected 0", pulses); end
        n_checks++; if (temperature !== 16'h0BAD || humidity !== 16'hF00D) begin n_fail++; $display("FAIL short_keep: got %04h %04h expected 0bad f00d", temperature, humidity); end
        n_checks++; if (error !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL short_error: got err %0b busy %0b expected 1 0", error, busy); end
    endtask

    task automatic test_timeout_and_reset();
        logic ok, rnw, dr; logic [2:0] sz; logic [31:0] wb; int pulses, cnt; logic [15:0] t, h;
        // a clean measurement first so the timeout has a cleared error to set
        pulse_measure();
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        master_txn(4, 32'h1111_2222, ok, sz, rnw, wb, dr);
        collect_result(pulses, t, h);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL error_cleared: got %0b expected 0", error); end
        pulse_measure();
        wait_start(ok);
        cnt = 0;
        while (bus.start === 1'b1 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        n_checks++; if (cnt < TO - 3 || cnt > TO + 3) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected %0d +/- 3", cnt, TO); end
        n_checks++; if (error !== 1'b1 || busy !== 1'b0 || bus.start !== 1'b0) begin n_fail++; $display("FAIL timeout_state: got err %0b busy %0b start %0b expected 1 0 0", error, busy, bus.start); end
        // reset in the middle of a read
        pulse_measure();
        master_txn(1, 32'h0, ok, sz, rnw, wb, dr);
        wait_start(ok);
        bus.ready = 1'b0;
        @(negedge clk);
        bus.data_o = 8'h77;
        bus.data_available = 1'b1;
        @(negedge clk);
        bus.data_available = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.start !== 1'b0 || result_valid !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got start %0b rv %0b err %0b expected 0 0 0", bus.start, result_valid, error); end
        n_checks++; if ({temperature, humidity} !== 32'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL midrst_outputs: got %08h busy %0b expected 00000000 1", {temperature, humidity}, busy); end
        bus.ready = 1'b1;
        heater = 1'b0;
        tres = 1'b1;
        hres = 2'b01;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        master_txn(3, 32'h0, ok, sz, rnw, wb, dr);
        n_checks++; if (ok !== 1'b1 || sz !== 3'd3 || wb[23:0] !== 24'h021500) begin n_fail++; $display("FAIL midrst_cfg: got ok %0b size %0d bytes %06h expected 1 3 021500", ok, sz, wb[23:0]); end
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got %0b expected 0", busy); end
    endtask

    initial begin
        bus.ready          = 1'b1;
        bus.i2cBusy        = 1'b0;
        bus.data_request   = 1'b0;
        bus.data_available = 1'b0;
        bus.data_o         = 8'h00;
        #2;
        test_reset();
        test_config();
        test_measure();
        test_cfg_priority();
        test_i2c_busy();
        test_short_read();
        test_timeout_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
